// File: rtl/video_dram_resp_pkg.sv
// Shared definitions for the video DRAM responder: the DRAM cycle owner encoding
// and the default bus widths.
package video_dram_resp_pkg;

    localparam int ADDR_W_DEF = 21;
    localparam int DATA_W_DEF = 16;
    localparam int CYC_W      = 3;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_CPU  = 2'd2
    } owner_e;

endpackage

// File: rtl/video_dram_resp_if.sv
// Video fetcher, CPU channel and DRAM controller signals around the responder.
// The master drives the requests; the slave is the responder itself.
interface video_dram_resp_if
    import video_dram_resp_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              cend;
    logic              fetch_start;
    logic              line_start;
    logic [ADDR_W-1:0] video_base;
    logic              video_bw;
    logic              video_go;
    logic [DATA_W-1:0] video_data;
    logic              video_strobe;

    logic              cpu_req;
    logic              cpu_rnw;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wrdata;
    logic [DATA_W-1:0] cpu_rddata;
    logic              cpu_strobe;

    logic              dram_req;
    logic              dram_rnw;
    logic [ADDR_W-1:0] dram_addr;
    logic [DATA_W-1:0] dram_wrdata;
    logic [DATA_W-1:0] dram_rddata;

    modport master (
        output cend, fetch_start, line_start, video_base, video_bw, video_go,
        output cpu_req, cpu_rnw, cpu_addr, cpu_wrdata, dram_rddata,
        input  video_data, video_strobe, cpu_rddata, cpu_strobe,
        input  dram_req, dram_rnw, dram_addr, dram_wrdata
    );

    modport slave (
        input  cend, fetch_start, line_start, video_base, video_bw, video_go,
        input  cpu_req, cpu_rnw, cpu_addr, cpu_wrdata, dram_rddata,
        output video_data, video_strobe, cpu_rddata, cpu_strobe,
        output dram_req, dram_rnw, dram_addr, dram_wrdata
    );

endinterface

// File: rtl/video_dram_resp_slot_sched.sv
// DRAM cycle index counter and video slot decode. is_vslot_o refers to the cycle
// that starts at the current cend.
module video_slot_sched
    import video_dram_resp_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic cend_i,
    input  logic fetch_start_i,
    input  logic video_bw_i,
    output logic is_vslot_o
);

    logic [CYC_W-1:0] cyc_q, cyc_d, nxt_cyc;

    always_comb begin
        nxt_cyc    = fetch_start_i ? '0 : cyc_q + CYC_W'(1);
        cyc_d      = cend_i ? nxt_cyc : cyc_q;
        is_vslot_o = video_bw_i ? (nxt_cyc[1:0] == 2'b00) : (nxt_cyc == '0);
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cyc_q <= '0;
        else     cyc_q <= cyc_d;
    end

endmodule

// File: rtl/video_dram_resp.sv
// DRAM-side responder: decides each DRAM cycle's owner (video, CPU or idle) at cend,
// drives the registered DRAM request and routes the returned word to the owner.
module video_dram_resp
    import video_dram_resp_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    video_dram_resp_if.slave  bus
);

    owner_e            owner_q, owner_d;
    logic              is_vslot;
    logic [ADDR_W-1:0] vaddr_q, vaddr_d, vid_addr;
    logic              dram_req_q, dram_req_d;
    logic              dram_rnw_q, dram_rnw_d;
    logic [ADDR_W-1:0] dram_addr_q, dram_addr_d;
    logic [DATA_W-1:0] dram_wrdata_q, dram_wrdata_d;

    video_slot_sched u_sched (
        .clk           (clk),
        .rst           (rst),
        .cend_i        (bus.cend),
        .fetch_start_i (bus.fetch_start),
        .video_bw_i    (bus.video_bw),
        .is_vslot_o    (is_vslot)
    );

    // line_start replaces the running address, and a same-cend grant fetches from it.
    assign vid_addr = bus.line_start ? bus.video_base : vaddr_q;

    always_comb begin
        // NOTE: every signal gets its hold value first, so no path leaves one
        // unassigned and no latch is inferred.
        owner_d       = owner_q;
        vaddr_d       = vaddr_q;
        dram_req_d    = dram_req_q;
        dram_rnw_d    = dram_rnw_q;
        dram_addr_d   = dram_addr_q;
        dram_wrdata_d = dram_wrdata_q;
        if (bus.cend) begin
            vaddr_d = vid_addr;
            if (is_vslot && bus.video_go)                owner_d = OWN_VID;
            else if (bus.cpu_req && owner_q != OWN_CPU)  owner_d = OWN_CPU;
            else                                         owner_d = OWN_IDLE;
            dram_req_d = (owner_d != OWN_IDLE);
            case (owner_d)
                OWN_VID: begin
                    dram_addr_d = vid_addr;
                    dram_rnw_d  = 1'b1;
                    vaddr_d     = vid_addr + ADDR_W'(1);
                end
                OWN_CPU: begin
                    dram_addr_d   = bus.cpu_addr;
                    dram_rnw_d    = bus.cpu_rnw;
                    dram_wrdata_d = bus.cpu_wrdata;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q       <= OWN_IDLE;
            vaddr_q       <= '0;
            dram_req_q    <= 1'b0;
            dram_rnw_q    <= 1'b0;
            dram_addr_q   <= '0;
            dram_wrdata_q <= '0;
        end else begin
            owner_q       <= owner_d;
            vaddr_q       <= vaddr_d;
            dram_req_q    <= dram_req_d;
            dram_rnw_q    <= dram_rnw_d;
            dram_addr_q   <= dram_addr_d;
            dram_wrdata_q <= dram_wrdata_d;
        end
    end

    assign bus.dram_req     = dram_req_q;
    assign bus.dram_rnw     = dram_rnw_q;
    assign bus.dram_addr    = dram_addr_q;
    assign bus.dram_wrdata  = dram_wrdata_q;

    assign bus.video_strobe = bus.cend && (owner_q == OWN_VID);
    assign bus.video_data   = bus.dram_rddata;
    assign bus.cpu_strobe   = bus.cend && (owner_q == OWN_CPU);
    assign bus.cpu_rddata   = bus.dram_rddata;

endmodule
